cacheline_adaptor: RTL and testbench
====================================

# cacheline_adaptor

Bridges the 256-bit cache-line physical-memory port of the memory hierarchy (pmem_address / pmem_rdata / pmem_wdata / pmem_read / pmem_write / pmem_resp) to a 64-bit burst DRAM model.

- Each line transfer becomes one 4-beat burst.
- It sits directly downstream of the memory hierarchy's last-level cache and is instantiated beside it at the top level.
- It serialises write-backs, deserialises fills, and aligns addresses.

## Interface
Parameters: none (line 256 b, beat 64 b, 4 beats fixed).
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- line_i  in  256  write-back line data (pmem_wdata from the cache)
- line_o  out  256  fill line data (pmem_rdata to the cache)
- address_i  in  32  line address (pmem_address)
- read_i  in  1  line read request, held high until resp_o
- write_i  in  1  line write request, held high until resp_o
- resp_o  out  1  one-cycle completion pulse (pmem_resp)
- burst_i  in  64  read beat data from DRAM
- burst_o  out  64  write beat data to DRAM
- address_o  out  32  burst address, line-aligned
- read_o  out  1  burst read request
- write_o  out  1  burst write request
- resp_i  in  1  DRAM beat strobe: one beat per cycle it is high

## Operation
- States:
  - IDLE
  - RD (read_o=1)
  - WR (write_o=1)
  - DONE (resp_o=1)
- All outputs are registered or decoded from state. None is combinational from inputs.
- IDLE:
  - write_i=1 → latch address_i and line_i, clear beat count, go to WR.
  - Otherwise read_i=1 → latch address_i, clear beat count, go to RD.
  - If both requests are high, write wins.
- address_o = {latched_addr[31:5], 5'b0}. It is held constant for the whole burst.
- RD:
  - Each cycle with resp_i=1, burst_i is stored into line_o[64k+63:64k], where k is the beat count (0..3). Then k increments.
  - On the beat with k=3 → DONE.
- WR:
  - burst_o = latched_line[64k+63:64k] for the current k.
  - Each cycle with resp_i=1 the beat counts as accepted and k increments.
  - On k=3 accepted → DONE.
- resp_i=0 inside RD/WR: beat count holds, so gaps between beats are tolerated. The burst stays open with read_o/write_o high.
- DONE: resp_o=1 for exactly one cycle → IDLE. read_i/write_i are ignored in DONE.
- line_o holds the last completed fill until the next read's first beat. Upstream samples it while resp_o=1.
- Request inputs are ignored outside IDLE. resp_i is ignored in IDLE and DONE.
- The beat counter is 2 bits; the k=3 beat ends the burst, so the counter never wraps within a burst.

## Timing
- Reset (async assert, sync-safe deassert) gives:
  - state IDLE
  - read_o=0, write_o=0, resp_o=0
  - address_o=0, burst_o=0, line_o=0
  - beat count 0
- Reset mid-burst aborts the burst immediately. The DRAM model must also be reset.
- Request is sampled at edge E0, and read_o/write_o are high from E0 onward.
- With DRAM responding at beats E1..E4, resp_o is high in the cycle after E4. Minimum line latency is 5 cycles from request sample to resp_o.
- The upstream request remains high during DONE and is dropped after resp_o. The earliest next request is sampled in the cycle after DONE, so back-to-back transfers have one idle cycle between them.
- burst_o changes only on an accepted beat, after the rising edge where resp_i=1.

## Test plan
- Reset: hold reset_n=0 with random inputs → all outputs 0. Release → IDLE, no read_o/write_o.
- Read fill:
  - Stimulus: read_i, address_i=0x0000_1234. DRAM returns beats 0x1111…11, 0x2222…22, 0x3333…33, 0x4444…44.
  - Required: address_o=0x0000_1220, and line_o={0x4444…,0x3333…,0x2222…,0x1111…} with resp_o pulsed once.
- Write-back:
  - Stimulus: write_i, line_i=256'h0123…_CDEF (beats D0..D3), address 0x8000_00FF.
  - Required: address_o=0x8000_00E0, burst_o=D0,D1,D2,D3 on successive accepted beats, then one resp_o.
- Gapped beats: resp_i pattern 1,0,0,1,1,0,1 → read_o stays high for the full burst, the data order is preserved, and resp_o comes 1 cycle after the 4th beat.
- Simultaneous read_i=write_i=1 → WR burst performed first. After resp_o, the read is serviced only if read_i is reasserted.
- Reset asserted after beat 2 of a read → immediate IDLE with outputs 0. A subsequent full read completes correctly.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Bridges the 256-bit cache-line memory port to a 64-bit, 4-beat burst DRAM interface.
// Write-backs are serialised, fills are deserialised, and burst addresses are line-aligned.
module cacheline_adaptor (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]   state_r;
  logic [1:0]   state_n_s;
  logic [1:0]   beat_r;
  logic [1:0]   beat_n_s;
  logic         beat_last_s;
  logic [255:0] wline_r;
  logic [255:0] line_r;
  logic [31:0]  addr_r;
  logic [63:0]  burst_r;
  logic         read_r;
  logic         write_r;
  logic         resp_r;

  assign beat_n_s    = beat_r + 2'd1;
  assign beat_last_s = (beat_r == 2'd3);

  // Next-state decode; write wins when both requests are raised together.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (write_i) begin
          state_n_s = WR;
        end else if (read_i) begin
          state_n_s = RD;
        end else begin
          state_n_s = IDLE;
        end
      end
      RD, WR: begin
        if (resp_i && beat_last_s) begin
          state_n_s = DONE;
        end else begin
          state_n_s = state_r;
        end
      end
      DONE:    state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
  end

  // State, handshake outputs and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      beat_r  <= 2'd0;
      wline_r <= 256'd0;
      line_r  <= 256'd0;
      addr_r  <= 32'd0;
      burst_r <= 64'd0;
      read_r  <= 1'b0;
      write_r <= 1'b0;
      resp_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      read_r  <= (state_n_s == RD);
      write_r <= (state_n_s == WR);
      resp_r  <= (state_n_s == DONE);
      case (state_r)
        IDLE: begin
          if (write_i) begin
            addr_r  <= address_i & 32'hFFFF_FFE0;
            wline_r <= line_i;
            burst_r <= line_i[63:0];
            beat_r  <= 2'd0;
          end else if (read_i) begin
            addr_r <= address_i & 32'hFFFF_FFE0;
            beat_r <= 2'd0;
          end
        end
        RD: begin
          // The fill lands in place, so line_o keeps the previous line until the first beat.
          if (resp_i) begin
            line_r[{beat_r, 6'd0} +: 64] <= burst_i;
            beat_r                       <= beat_n_s;
          end
        end
        WR: begin
          if (resp_i) begin
            beat_r <= beat_n_s;
            if (!beat_last_s) begin
              burst_r <= wline_r[{beat_n_s, 6'd0} +: 64];
            end
          end
        end
        DONE: begin
          beat_r <= 2'd0;
        end
        default: begin
          beat_r <= 2'd0;
        end
      endcase
    end
  end

  assign line_o    = line_r;
  assign burst_o   = burst_r;
  assign address_o = addr_r;
  assign read_o    = read_r;
  assign write_o   = write_r;
  assign resp_o    = resp_r;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: a transaction-level model is compared every
// cycle, and literal expectations pin fills, write beats, alignment and reset.
module tb_cacheline_adaptor;

  logic         clk;
  logic         reset_n;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  cacheline_adaptor dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transaction-level model: what kind of transfer is open, how many beats it has taken.
  int           m_kind  = 0;   // 0 none, 1 read, 2 write
  int           m_beats = 0;
  bit           m_done  = 1'b0;
  logic [31:0]  m_addr  = 32'd0;
  logic [255:0] m_wline = 256'd0;
  logic [255:0] m_fill  = 256'd0;
  logic [63:0]  m_burst = 64'd0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_kind <= 0; m_beats <= 0; m_done <= 1'b0; m_addr <= 32'd0;
      m_wline <= 256'd0; m_fill <= 256'd0; m_burst <= 64'd0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_kind <= 0;
    end else if (m_kind == 0) begin
      if (write_i) begin
        m_kind <= 2; m_beats <= 0; m_addr <= address_i / 32 * 32;
        m_wline <= line_i; m_burst <= line_i[63:0];
      end else if (read_i) begin
        m_kind <= 1; m_beats <= 0; m_addr <= address_i / 32 * 32;
      end
    end else if (resp_i) begin
      if (m_kind == 1) m_fill[m_beats*64 +: 64] <= burst_i;
      if (m_kind == 2 && m_beats < 3) m_burst <= m_wline[(m_beats+1)*64 +: 64];
      if (m_beats == 3) m_done <= 1'b1;
      m_beats <= m_beats + 1;
    end
  end

  // Per-cycle comparison of every DUT output against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_read_o",    {255'd0, read_o},  {255'd0, (m_kind == 1 && !m_done)});
      chk("m_write_o",   {255'd0, write_o}, {255'd0, (m_kind == 2 && !m_done)});
      chk("m_resp_o",    {255'd0, resp_o},  {255'd0, m_done});
      chk("m_address_o", {224'd0, address_o}, {224'd0, m_addr});
      chk("m_burst_o",   {192'd0, burst_o}, {192'd0, m_burst});
      chk("m_line_o",    line_o, m_fill);
    end
  end

  // One line transfer; pat is the resp_i pattern (LSB first) covering plen cycles.
  task automatic xfer(input bit wr, input bit rd, input logic [31:0] addr,
                      input logic [255:0] wline, input logic [255:0] fill,
                      input int plen, input logic [15:0] pat,
                      output logic [255:0] cap);
    int k;
    k = 0;
    cap = 256'd0;
    write_i = wr; read_i = rd; address_i = addr; line_i = wline;
    @(negedge clk);
    for (int i = 0; i < plen; i++) begin
      resp_i = pat[i];
      if (pat[i]) begin
        cap[k*64 +: 64] = burst_o;
        burst_i = fill[k*64 +: 64];
        k++;
      end else begin
        burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      @(negedge clk);
      if (i < plen - 1) chk("busy_no_resp", {255'd0, resp_o}, 256'd0);
    end
    resp_i = 1'b0;
    burst_i = 64'd0;
    chk("resp_pulse", {255'd0, resp_o}, 256'd1);
    write_i = 1'b0; read_i = 1'b0;
    @(negedge clk);
    chk("resp_single", {255'd0, resp_o}, 256'd0);
  endtask

  localparam logic [255:0] FILL_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] WLINE  = 256'h0123_4567_89AB_CDEF_1122_3344_5566_7788_99AA_BBCC_DDEE_FF00_FEDC_BA98_7654_CDEF;
  localparam logic [255:0] FILL_B = {64'hB4B4_B4B4_0000_0004, 64'hB3B3_B3B3_0000_0003,
                                     64'hB2B2_B2B2_0000_0002, 64'hB1B1_B1B1_0000_0001};

  logic [255:0] cap;

  initial begin
    reset_n = 1'b1;
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = 32'd0; line_i = 256'd0; burst_i = 64'd0;
    #2 reset_n = 1'b0;
    cmp_en = 1'b1;
    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      read_i = 1'($urandom); write_i = 1'($urandom); resp_i = 1'($urandom);
      address_i = $urandom; burst_i = {$urandom, $urandom};
      line_i = {8{$urandom}};
    end
    @(negedge clk);
    chk("rst_outputs", {line_o, burst_o, address_o, read_o, write_o, resp_o} != 0 ? 256'd1 : 256'd0, 256'd0);
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_idle", {254'd0, read_o, write_o}, 256'd0);

    // Read fill, back-to-back beats.
    write_i = 1'b0; read_i = 1'b1; address_i = 32'h0000_1234;
    @(negedge clk);
    chk("rd_addr_align", {224'd0, address_o}, {224'd0, 32'h0000_1220});
    chk("rd_read_o", {255'd0, read_o}, 256'd1);
    resp_i = 1'b1; burst_i = FILL_A[63:0];    @(negedge clk);
    burst_i = FILL_A[127:64];                 @(negedge clk);
    burst_i = FILL_A[191:128];                @(negedge clk);
    burst_i = FILL_A[255:192];                @(negedge clk);
    resp_i = 1'b0;
    chk("rd_resp_latency", {255'd0, resp_o}, 256'd1);
    chk("rd_line", line_o, FILL_A);
    read_i = 1'b0;
    @(negedge clk);
    chk("rd_resp_once", {255'd0, resp_o}, 256'd0);
    chk("rd_line_hold", line_o, FILL_A);

    // Write-back.
    xfer(1'b1, 1'b0, 32'h8000_00FF, WLINE, 256'd0, 4, 16'b1111, cap);
    chk("wr_beats", cap, WLINE);
    chk("wr_line_o_kept", line_o, FILL_A);

    // Gapped read beats 1,0,0,1,1,0,1.
    xfer(1'b0, 1'b1, 32'h0000_4040, 256'd0, FILL_B, 7, 16'b1011001, cap);
    chk("gap_line", line_o, FILL_B);

    // Simultaneous request: write first, read only when reasserted.
    xfer(1'b1, 1'b1, 32'h0000_0A00, WLINE, 256'd0, 4, 16'b1111, cap);
    chk("both_wr_first", cap, WLINE);
    @(negedge clk);
    chk("both_no_read", {254'd0, read_o, write_o}, 256'd0);
    xfer(1'b0, 1'b1, 32'h0000_0A00, 256'd0, FILL_A, 4, 16'b1111, cap);
    chk("both_read_after", line_o, FILL_A);

    // Reset after beat 2 of a read, then a full read.
    read_i = 1'b1; address_i = 32'h0000_2000;
    @(negedge clk);
    resp_i = 1'b1; burst_i = 64'h5555_5555_5555_5555; @(negedge clk);
    burst_i = 64'h6666_6666_6666_6666;                @(negedge clk);
    resp_i = 1'b0; read_i = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("abort_outputs", {line_o, burst_o, address_o, read_o, write_o, resp_o} != 0 ? 256'd1 : 256'd0, 256'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    xfer(1'b0, 1'b1, 32'h0000_3FFF, 256'd0, FILL_B, 5, 16'b10111, cap);
    chk("abort_reread", line_o, FILL_B);
    chk("abort_addr", {224'd0, address_o}, {224'd0, 32'h0000_3FE0});

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
